// File: rtl/nco_pkg.sv
// Shared types and default widths for the NCO phase generator.
package nco_pkg;

    localparam int unsigned ACC_W_DEF   = 24;
    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned DIV_W_DEF   = 16;
    localparam int unsigned QUAD_OFFSET = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } nco_state_t;

    // Active and shadow configuration share one layout.
    typedef struct packed {
        logic [ACC_W_DEF-1:0]  ftw;
        logic [ADDR_W_DEF-1:0] phase;
        logic [DIV_W_DEF-1:0]  div;
    } nco_cfg_t;

endpackage

// File: rtl/nco_tick_div.sv
// Sample-rate divider: ticks once every div+1 enabled clocks, held at 0 when disabled.
module nco_tick_div #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // >= keeps the counter bounded if div shrinks while the count is above it.
    always_comb begin
        tick  = en && (cnt_q >= div);
        cnt_d = '0;
        if (en && !tick) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nco_phase_gen.sv
// NCO phase accumulator feeding the sine LUT address, with run/stop FSM and wrap-synchronous config.
// Optional quadrature address output enabled by defining NCO_QUAD_OUT_EN.
module nco_phase_gen
    import nco_pkg::*;
#(
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DIV_W  = DIV_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ACC_W-1:0]  cfg_ftw,
    input  logic [ADDR_W-1:0] cfg_phase,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] address,
`ifdef NCO_QUAD_OUT_EN
    output logic [ADDR_W-1:0] address_q,
`endif
    output logic              sample_valid,
    output logic              wrap,
    output logic              busy
);

    nco_state_t        state_q, state_d;
    nco_cfg_t          act_q, act_d, shd_q, shd_d, cfg_word;
    logic [ACC_W-1:0]  acc_q, acc_d, sum;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] quad_q, quad_d;
    logic              sv_q, sv_d, wrap_q, wrap_d;
    logic              busy_q, busy_d, pend_q, pend_d, rdy_q, rdy_d;
    logic              tick, carry, fire, cfg_fire;

    nco_tick_div #(.DIV_W(DIV_W)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .div  (DIV_W'(act_q.div)),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            act_q   <= '0;
            shd_q   <= '0;
            acc_q   <= '0;
            addr_q  <= '0;
            quad_q  <= ADDR_W'(QUAD_OFFSET);
            sv_q    <= 1'b0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            quad_q  <= quad_d;
            sv_q    <= sv_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            rdy_q   <= rdy_d;
        end
    end

    // A held stop in STOPPING wins over any coincident tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start && !stop) state_d = RUN;
            RUN:      if (stop) state_d = STOPPING;
            STOPPING: if (stop || (tick && carry)) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d    = acc_q;
        addr_d   = addr_q;
        quad_d   = quad_q;
        sv_d     = 1'b0;
        wrap_d   = 1'b0;
        act_d    = act_q;
        shd_d    = shd_q;
        pend_d   = pend_q;
        cfg_word = '{ftw:   ACC_W_DEF'(cfg_ftw),
                     phase: ADDR_W_DEF'(cfg_phase),
                     div:   DIV_W_DEF'(cfg_div)};
        cfg_fire = cfg_valid && rdy_q;
        {carry, sum} = {1'b0, acc_q} + {1'b0, ACC_W'(act_q.ftw)};
        fire = tick && ((state_q == RUN) || ((state_q == STOPPING) && !stop));

        if (state_q == IDLE) begin
            if (start && !stop) acc_d = '0;
            if (cfg_fire) act_d = cfg_word;
        end else if (cfg_fire) begin
            shd_d  = cfg_word;
            pend_d = 1'b1;
        end

        if (fire) begin
            addr_d = acc_q[ACC_W-1 -: ADDR_W] + ADDR_W'(act_q.phase);
            quad_d = addr_d + ADDR_W'(QUAD_OFFSET);
            acc_d  = sum;
            sv_d   = 1'b1;
            wrap_d = carry;
            // New config lands on the wrap so the next cycle starts clean.
            if (carry && pend_q) begin
                act_d  = shd_q;
                pend_d = 1'b0;
            end
        end

        if ((state_q != IDLE) && (state_d == IDLE) && pend_d) begin
            act_d  = shd_d;
            pend_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
        rdy_d  = !pend_d;
    end

    assign address      = addr_q;
    assign sample_valid = sv_q;
    assign wrap         = wrap_q;
    assign busy         = busy_q;
    assign cfg_ready    = rdy_q;
`ifdef NCO_QUAD_OUT_EN
    assign address_q    = quad_q;
`endif

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed self-checking bench for nco_phase_gen (quadrature output checked when NCO_QUAD_OUT_EN is defined).
module tb_nco_phase_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [23:0] cfg_ftw;
    logic [7:0]  cfg_phase;
    logic [15:0] cfg_div;
    logic        start;
    logic        stop;
    logic [7:0]  address;
`ifdef NCO_QUAD_OUT_EN
    logic [7:0]  address_q;
`endif
    logic        sample_valid;
    logic        wrap;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nco_phase_gen dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ftw      (cfg_ftw),
        .cfg_phase    (cfg_phase),
        .cfg_div      (cfg_div),
        .start        (start),
        .stop         (stop),
        .address      (address),
`ifdef NCO_QUAD_OUT_EN
        .address_q    (address_q),
`endif
        .sample_valid (sample_valid),
        .wrap         (wrap),
        .busy         (busy)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_ftw = '0; cfg_phase = '0; cfg_div = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic load_cfg(input logic [23:0] f, input logic [7:0] p, input logic [15:0] d);
        cfg_ftw = f; cfg_phase = p; cfg_div = d; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({address, sample_valid, wrap, busy, cfg_ready} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_values got addr=%0d sv=%b wrap=%b busy=%b rdy=%b want 0 0 0 0 1",
                     address, sample_valid, wrap, busy, cfg_ready);
        end
`ifdef NCO_QUAD_OUT_EN
        checks++;
        if (address_q !== 8'd64) begin
            failures++;
            $display("FAIL reset_quad got %0d want 64", address_q);
        end
`endif
        load_cfg(24'h010000, 8'd0, 16'd0);
        pulse_start();
        repeat (5) step();
        cfg_ftw = 24'h020000; cfg_phase = 8'h33; cfg_div = 16'd0; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL pending_ready got %b want 0", cfg_ready);
        end
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if ({address, sample_valid, busy, cfg_ready} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL midrun_reset got addr=%0d sv=%b busy=%b rdy=%b want 0 0 0 1",
                     address, sample_valid, busy, cfg_ready);
        end
        // Active config is all-zero now: ftw=0 keeps the address at 0 with no wrap.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({sample_valid, address, wrap, busy} !== {1'b1, 8'd0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL pending_lost i=%0d got sv=%b addr=%0d wrap=%b busy=%b want 1 0 0 1",
                         i, sample_valid, address, wrap, busy);
            end
        end
        stop = 1'b1;
        step(); step();
        stop = 1'b0;
        checks++;
        if ({busy, sample_valid} !== 2'b00) begin
            failures++;
            $display("FAIL double_stop got busy=%b sv=%b want 0 0", busy, sample_valid);
        end
    endtask

    task automatic test_basic_sweep();
        logic [7:0] ea;
        do_reset();
        load_cfg(24'h010000, 8'd0, 16'd0);
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_cfg_ready got %b want 1", cfg_ready);
        end
        pulse_start();
        checks++;
        if (sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_latency got sv=%b want 0", sample_valid);
        end
        for (int i = 0; i < 260; i++) begin
            step();
            ea = 8'(i);
            checks++;
            if ({sample_valid, address, wrap} !== {1'b1, ea, (ea == 8'd255)}) begin
                failures++;
                $display("FAIL sweep i=%0d got sv=%b addr=%0d wrap=%b want 1 %0d %b",
                         i, sample_valid, address, wrap, ea, (ea == 8'd255));
            end
        end
    endtask

    task automatic test_divider();
        logic [7:0] ea;
        logic       es;
        do_reset();
        load_cfg(24'h010000, 8'd0, 16'd3);
        pulse_start();
        for (int c = 1; c <= 20; c++) begin
            step();
            es = ((c % 4) == 0);
            ea = (c < 4) ? 8'd0 : 8'(c / 4 - 1);
            checks++;
            if ({sample_valid, address} !== {es, ea}) begin
                failures++;
                $display("FAIL div3 c=%0d got sv=%b addr=%0d want %b %0d",
                         c, sample_valid, address, es, ea);
            end
        end
    endtask

    task automatic test_phase_offset();
        logic [7:0] ea;
        do_reset();
        load_cfg(24'h010000, 8'd64, 16'd0);
        pulse_start();
        for (int i = 0; i < 260; i++) begin
            step();
            ea = 8'(i + 64);
            checks++;
            if ({sample_valid, address, wrap} !== {1'b1, ea, ((i % 256) == 255)}) begin
                failures++;
                $display("FAIL phase64 i=%0d got sv=%b addr=%0d wrap=%b want 1 %0d %b",
                         i, sample_valid, address, wrap, ea, ((i % 256) == 255));
            end
`ifdef NCO_QUAD_OUT_EN
            checks++;
            if (address_q !== 8'(i + 128)) begin
                failures++;
                $display("FAIL quad i=%0d got %0d want %0d", i, address_q, 8'(i + 128));
            end
`endif
        end
    endtask

    task automatic test_stop();
        do_reset();
        load_cfg(24'h010000, 8'd0, 16'd0);
        pulse_start();
        repeat (101) step();
        checks++;
        if (address !== 8'd100) begin
            failures++;
            $display("FAIL stop_setup got addr=%0d want 100", address);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int a = 101; a <= 255; a++) begin
            checks++;
            if ({sample_valid, address, wrap, busy} !== {1'b1, 8'(a), (a == 255), (a != 255)}) begin
                failures++;
                $display("FAIL stopping a=%0d got sv=%b addr=%0d wrap=%b busy=%b want 1 %0d %b %b",
                         a, sample_valid, address, wrap, busy, a, (a == 255), (a != 255));
            end
            step();
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({busy, sample_valid, address} !== {1'b0, 1'b0, 8'd255}) begin
                failures++;
                $display("FAIL after_stop k=%0d got busy=%b sv=%b addr=%0d want 0 0 255",
                         k, busy, sample_valid, address);
            end
            step();
        end
    endtask

    task automatic test_cfg_update();
        logic [7:0] ea;
        do_reset();
        load_cfg(24'h010000, 8'd0, 16'd0);
        pulse_start();
        repeat (11) step();
        cfg_ftw = 24'h020000; cfg_phase = 8'd0; cfg_div = 16'd0; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        for (int a = 11; a <= 255; a++) begin
            checks++;
            if ({address, wrap, cfg_ready} !== {8'(a), (a == 255), (a == 255)}) begin
                failures++;
                $display("FAIL shadow a=%0d got addr=%0d wrap=%b rdy=%b want %0d %b %b",
                         a, address, wrap, cfg_ready, a, (a == 255), (a == 255));
            end
            step();
        end
        for (int j = 0; j < 130; j++) begin
            ea = 8'(2 * j);
            checks++;
            if ({sample_valid, address, wrap, cfg_ready} !== {1'b1, ea, ((j % 128) == 127), 1'b1}) begin
                failures++;
                $display("FAIL new_ftw j=%0d got sv=%b addr=%0d wrap=%b rdy=%b want 1 %0d %b 1",
                         j, sample_valid, address, wrap, cfg_ready, ea, ((j % 128) == 127));
            end
            step();
        end
    endtask

    task automatic test_start_stop_priority();
        do_reset();
        load_cfg(24'h010000, 8'd0, 16'd0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step();
        checks++;
        if ({busy, sample_valid} !== 2'b00) begin
            failures++;
            $display("FAIL start_stop_prio got busy=%b sv=%b want 0 0", busy, sample_valid);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_sweep();
        test_divider();
        test_phase_offset();
        test_stop();
        test_cfg_update();
        test_start_stop_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nco_phase_gen.md
Name: nco_phase_gen

Overview:
Numerically controlled phase accumulator that drives the 8-bit address input of the sine lookup table, one stage upstream of it. A run/stop state machine and a programmable sample-rate divider control when the accumulator advances. Frequency, phase offset and rate are loaded through a valid/ready config port. Config changes made while running take effect only at a waveform wrap, so output frequency changes are glitch-free.

Parameters:
ACC_W, 24, accumulator width in bits; the address is the top ADDR_W bits.
ADDR_W, 8, LUT address width; fixed at 8 to match the sine table.
DIV_W, 16, sample-rate divider width.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
cfg_valid  in  1  config word offered.
cfg_ready  out  1  config word can be accepted.
cfg_ftw  in  ACC_W  frequency tuning word (accumulator increment per tick).
cfg_phase  in  ADDR_W  phase offset added to the address.
cfg_div  in  DIV_W  tick every cfg_div+1 clocks.
start  in  1  begin generation (level sampled).
stop  in  1  request stop at the end of the current cycle.
address  out  ADDR_W  registered LUT address.
sample_valid  out  1  one-clock strobe: address holds a new sample.
wrap  out  1  accumulator carried out on this sample (last sample of the cycle).
busy  out  1  state is not IDLE.

Behaviour:
- Reset values: acc=0, address=0, sample_valid=0, wrap=0, busy=0, cfg_ready=1, state=IDLE. Active ftw, phase and div are 0. Shadow config is cleared and the pending flag is cleared.
- Reset mid-operation aborts immediately to the reset values. Any pending config is discarded.
- States:
  - IDLE: on start=1 and stop=0, clear acc and the divider count, go to RUN. If start and stop are high together, stay in IDLE (stop has priority).
  - RUN: on stop, go to STOPPING. A start in RUN is ignored.
  - STOPPING: on the first tick with carry, emit that sample, then go to IDLE. A second stop while in STOPPING forces IDLE on the next clock with no further samples.
- Tick generation: the divider counts 0..div and ticks when count==div, then restarts at 0. div=0 gives one tick per clock. The divider holds at 0 in IDLE.
- On each tick in RUN or STOPPING:
  - address <= acc[ACC_W-1 -: ADDR_W] + phase, modulo 256.
  - {carry,acc} <= acc + ftw, wrapping modulo 2^ACC_W.
  - sample_valid <= 1 and wrap <= carry. Both are 0 on every non-tick clock.
- Latency: if start is sampled at edge E0, the first tick is at edge E0+div+1. The first address equals phase.
- address holds its value between ticks and after stopping.
- ftw=0: address stays constant and no wrap occurs. STOPPING then exits only by a second stop.
- Config handshake: transfer happens when cfg_valid && cfg_ready.
  - In IDLE, the active config is loaded on the next clock and cfg_ready stays 1.
  - In RUN or STOPPING, the word goes to the shadow registers, pending=1 and cfg_ready=0. The shadow is copied to active on the clock after the next carry tick, then pending=0 and cfg_ready=1.
  - acc is not cleared on this update.
  - If the block enters IDLE with pending=1, the shadow is applied on that same transition.
- busy = (state != IDLE).

Optional Feature:
NCO_QUAD_OUT_EN
- Defined: adds output address_q [ADDR_W], registered on the same ticks as address, equal to address + 64 modulo 256 (a quadrature/cosine address for a second LUT). Its reset value is 64.
- Undefined: no port and no logic.

Decomposition:
- Package nco_pkg holds:
  - ACC_W_DEF, ADDR_W_DEF, DIV_W_DEF, and QUAD_OFFSET=64.
  - typedef enum logic [1:0] nco_state_t {IDLE, RUN, STOPPING}.
  - typedef struct packed nco_cfg_t {ftw, phase, div}, used for both active and shadow config.
- One sub-module: nco_tick_div, the divider counter with inputs clk, rst, en, div and output tick.

Test Plan:
1. Assert rst for 3 clocks mid-RUN -> next clock: address=0, sample_valid=0, busy=0, cfg_ready=1; a pending config is lost.
2. cfg ftw=0x010000, phase=0, div=0, then start -> addresses 0,1,2,...,255 on consecutive clocks, sample_valid continuously high, wrap=1 only with address 255, then 0 repeats.
3. div=3, ftw=0x010000 -> sample_valid high on 1 of every 4 clocks; address steps by 1 per strobe.
4. phase=64 (with NCO_QUAD_OUT_EN, address_q checked) -> first address=64, address_q=128; address 255 wraps to 0 correctly.
5. ftw=0x010000, stop asserted when address=100 -> samples continue through 255 with wrap=1, busy=0 the following clock, no further sample_valid.
6. In RUN with ftw=0x010000, load ftw=0x020000 at address 10 -> cfg_ready=0 until wrap; after the wrap, addresses 0,2,4,...; cfg_ready returns to 1.
